// File: rtl/fifo_readback_checker.sv
// fifo_readback_checker: consumes the FIFO read port and checks each burst
// against the incrementing pattern FIRST_VAL, FIRST_VAL+1, ... (mod 2^DATA_W).
// Reports pass/fail, a saturating mismatch count, timeout, overrun and underflow.
// Optional build macro: FIRST_ERR_CAPTURE_EN adds capture registers for the
// index, expected value and actual value of the first mismatch.
module fifo_readback_checker #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_LEN = 32,
  parameter int unsigned FIRST_VAL = 1,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned ERR_W     = 8
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              rd_ready,
  input  logic              empty,
  input  logic              clr,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              timeout,
  output logic              overrun,
  output logic              underflow,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_act
);

  // Gap counter must be able to hold TIMEOUT-1.
  localparam int unsigned GAP_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;
  localparam logic [GAP_W-1:0]  GAP_LIMIT = GAP_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BURST_LEN);
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;
  localparam logic [DATA_W-1:0] BASE_VAL  = DATA_W'(FIRST_VAL);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              empty_q;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              timeout_q, timeout_d;
  logic              overrun_q, overrun_d;
  logic              underflow_q, underflow_d;

  logic [DATA_W-1:0] exp_val_c;
  logic [CNT_W-1:0]  beat_inc_c;
  logic [GAP_W-1:0]  gap_inc_c;
  logic              last_beat_c;
  logic              mismatch_c;

  // Expected value of the current beat; wraps naturally at DATA_W bits.
  assign exp_val_c   = BASE_VAL + DATA_W'(beat_cnt_q);
  assign beat_inc_c  = beat_cnt_q + CNT_W'(1);
  assign gap_inc_c   = gap_q + GAP_W'(1);
  assign last_beat_c = (beat_inc_c == LAST_CNT);
  assign mismatch_c  = rd_ready && (state_q != S_DONE) && (fifo_dout != exp_val_c);

`ifdef FIRST_ERR_CAPTURE_EN
  logic [CNT_W-1:0]  fe_idx_q, fe_idx_d;
  logic [DATA_W-1:0] fe_exp_q, fe_exp_d;
  logic [DATA_W-1:0] fe_act_q, fe_act_d;
`endif

  // Next-state and result computation; clr overrides everything incl. a same-cycle beat.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    gap_d       = gap_q;
    err_cnt_d   = err_cnt_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_d      = fail_q;
    timeout_d   = timeout_q;
    overrun_d   = overrun_q;
    underflow_d = underflow_q;
`ifdef FIRST_ERR_CAPTURE_EN
    fe_idx_d    = fe_idx_q;
    fe_exp_d    = fe_exp_q;
    fe_act_d    = fe_act_q;
`endif

    if (clr) begin
      state_d     = S_IDLE;
      beat_cnt_d  = '0;
      gap_d       = '0;
      err_cnt_d   = '0;
      pass_d      = 1'b0;
      fail_d      = 1'b0;
      timeout_d   = 1'b0;
      overrun_d   = 1'b0;
      underflow_d = 1'b0;
`ifdef FIRST_ERR_CAPTURE_EN
      fe_idx_d    = '0;
      fe_exp_d    = '0;
      fe_act_d    = '0;
`endif
    end else begin
      if (mismatch_c) begin
        if (err_cnt_q != ERR_MAX) begin
          err_cnt_d = err_cnt_q + ERR_W'(1);
        end
        fail_d = 1'b1;
      end

`ifdef FIRST_ERR_CAPTURE_EN
      // err_cnt saturates and never returns to zero, so zero means "no error yet".
      if (mismatch_c && (err_cnt_q == '0)) begin
        fe_idx_d = beat_cnt_q;
        fe_exp_d = exp_val_c;
        fe_act_d = fifo_dout;
      end
`endif

      // empty_q is the empty flag seen when this beat's read was issued.
      if (rd_ready && empty_q) begin
        underflow_d = 1'b1;
        fail_d      = 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (rd_ready) begin
            beat_cnt_d = beat_inc_c;
            gap_d      = '0;
            state_d    = last_beat_c ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (rd_ready) begin
            beat_cnt_d = beat_inc_c;
            gap_d      = '0;
            if (last_beat_c) begin
              state_d = S_DONE;
            end
          end else begin
            gap_d = gap_inc_c;
            if (gap_inc_c >= GAP_LIMIT) begin
              timeout_d = 1'b1;
              fail_d    = 1'b1;
              state_d   = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (rd_ready) begin
            overrun_d = 1'b1;
            fail_d    = 1'b1;
            pass_d    = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      // Results become visible together with the one-cycle done pulse.
      if ((state_q != S_DONE) && (state_d == S_DONE)) begin
        done_d = 1'b1;
        pass_d = !fail_d;
      end
    end
  end

  // State register.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Empty flag pipeline; follows the FIFO every cycle, unaffected by clr.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      empty_q <= 1'b0;
    end else begin
      empty_q <= empty;
    end
  end

  // Result and counter registers.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      beat_cnt_q  <= '0;
      gap_q       <= '0;
      err_cnt_q   <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      gap_q       <= gap_d;
      err_cnt_q   <= err_cnt_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef FIRST_ERR_CAPTURE_EN
  // First-mismatch capture registers.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      fe_idx_q <= '0;
      fe_exp_q <= '0;
      fe_act_q <= '0;
    end else begin
      fe_idx_q <= fe_idx_d;
      fe_exp_q <= fe_exp_d;
      fe_act_q <= fe_act_d;
    end
  end

  assign first_err_idx = fe_idx_q;
  assign first_err_exp = fe_exp_q;
  assign first_err_act = fe_act_q;
`else
  assign first_err_idx = '0;
  assign first_err_exp = '0;
  assign first_err_act = '0;
`endif

  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign err_cnt   = err_cnt_q;
  assign beat_cnt  = beat_cnt_q;
  assign timeout   = timeout_q;
  assign overrun   = overrun_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_readback_checker.sv
// Scoreboard bench for fifo_readback_checker: directed bursts push the
// expected end-of-burst result; monitors pop and compare on each done pulse.
module tb_fifo_readback_checker;

  logic       sysclk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] fifo_dout = '0;
  logic       rd_ready = 1'b0;
  logic       empty = 1'b0;
  logic       clr = 1'b0;

  logic       done_a, pass_a, fail_a, timeout_a, overrun_a, underflow_a;
  logic [7:0] err_cnt_a, fe_exp_a, fe_act_a;
  logic [9:0] beat_cnt_a, fe_idx_a;

  logic [7:0] dout_b = '0;
  logic       rd_ready_b = 1'b0;
  logic       empty_b = 1'b0;
  logic       clr_b = 1'b0;
  logic       done_b, pass_b, fail_b, timeout_b, overrun_b, underflow_b;
  logic [7:0] err_cnt_b, fe_exp_b, fe_act_b;
  logic [9:0] beat_cnt_b, fe_idx_b;

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int pass;
    int fail;
    int timeout;
    int overrun;
    int underflow;
    int err_cnt;
    int beat_cnt;
    int fe_idx;
    int fe_exp;
    int fe_act;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea;
  exp_t eb;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef FIRST_ERR_CAPTURE_EN
  localparam int FE_IDX = 4;
  localparam int FE_EXP = 8'h05;
  localparam int FE_ACT = 8'h55;
`else
  localparam int FE_IDX = 0;
  localparam int FE_EXP = 0;
  localparam int FE_ACT = 0;
`endif

  fifo_readback_checker u_dut_a (
    .sysclk        (sysclk),
    .rst           (rst),
    .fifo_dout     (fifo_dout),
    .rd_ready      (rd_ready),
    .empty         (empty),
    .clr           (clr),
    .done          (done_a),
    .pass          (pass_a),
    .fail          (fail_a),
    .err_cnt       (err_cnt_a),
    .beat_cnt      (beat_cnt_a),
    .timeout       (timeout_a),
    .overrun       (overrun_a),
    .underflow     (underflow_a),
    .first_err_idx (fe_idx_a),
    .first_err_exp (fe_exp_a),
    .first_err_act (fe_act_a)
  );

  fifo_readback_checker #(.FIRST_VAL(240)) u_dut_b (
    .sysclk        (sysclk),
    .rst           (rst),
    .fifo_dout     (dout_b),
    .rd_ready      (rd_ready_b),
    .empty         (empty_b),
    .clr           (clr_b),
    .done          (done_b),
    .pass          (pass_b),
    .fail          (fail_b),
    .err_cnt       (err_cnt_b),
    .beat_cnt      (beat_cnt_b),
    .timeout       (timeout_b),
    .overrun       (overrun_b),
    .underflow     (underflow_b),
    .first_err_idx (fe_idx_b),
    .first_err_exp (fe_exp_b),
    .first_err_act (fe_act_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, expv, expv, cyc);
    end
  endtask

  // One stimulus cycle on DUT A, driven just after the rising edge.
  task automatic drive(input logic rdy, input logic [7:0] d, input logic emp, input logic c);
    @(posedge sysclk);
    #1;
    rd_ready  = rdy;
    fifo_dout = d;
    empty     = emp;
    clr       = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic pulse_clr();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // n back-to-back beats 0x01.. with optional bad beat and an empty flag ahead of beat emp_idx.
  task automatic run_burst(input int n, input int bad_idx, input logic [7:0] bad_val, input int emp_idx);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = 8'(i + 1);
      if (i == bad_idx) d = bad_val;
      drive(1'b1, d, (i == emp_idx - 1), 1'b0);
    end
  endtask

  // Monitor for DUT A.
  always @(negedge sysclk) begin
    if (done_a === 1'b1) begin
      if (q_a.size() == 0) begin
        chk("spurious_done_a", 32'(done_a), 32'd0);
      end else begin
        ea = q_a.pop_front();
        chk("done_cycle_a", cyc,                ea.cyc);
        chk("pass_a",       32'(pass_a),        ea.pass);
        chk("fail_a",       32'(fail_a),        ea.fail);
        chk("timeout_a",    32'(timeout_a),     ea.timeout);
        chk("overrun_a",    32'(overrun_a),     ea.overrun);
        chk("underflow_a",  32'(underflow_a),   ea.underflow);
        chk("err_cnt_a",    32'(err_cnt_a),     ea.err_cnt);
        chk("beat_cnt_a",   32'(beat_cnt_a),    ea.beat_cnt);
        chk("fe_idx_a",     32'(fe_idx_a),      ea.fe_idx);
        chk("fe_exp_a",     32'(fe_exp_a),      ea.fe_exp);
        chk("fe_act_a",     32'(fe_act_a),      ea.fe_act);
      end
    end
  end

  // Monitor for DUT B (wrapping pattern).
  always @(negedge sysclk) begin
    if (done_b === 1'b1) begin
      if (q_b.size() == 0) begin
        chk("spurious_done_b", 32'(done_b), 32'd0);
      end else begin
        eb = q_b.pop_front();
        chk("done_cycle_b", cyc,              eb.cyc);
        chk("pass_b",       32'(pass_b),      eb.pass);
        chk("fail_b",       32'(fail_b),      eb.fail);
        chk("err_cnt_b",    32'(err_cnt_b),   eb.err_cnt);
        chk("beat_cnt_b",   32'(beat_cnt_b),  eb.beat_cnt);
        chk("underflow_b",  32'(underflow_b), eb.underflow);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values.
    repeat (2) @(posedge sysclk);
    #1;
    chk("rst_done",      32'(done_a),      32'd0);
    chk("rst_pass",      32'(pass_a),      32'd0);
    chk("rst_fail",      32'(fail_a),      32'd0);
    chk("rst_err_cnt",   32'(err_cnt_a),   32'd0);
    chk("rst_beat_cnt",  32'(beat_cnt_a),  32'd0);
    chk("rst_timeout",   32'(timeout_a),   32'd0);
    chk("rst_overrun",   32'(overrun_a),   32'd0);
    chk("rst_underflow", 32'(underflow_a), 32'd0);
    rst = 1'b0;

    // Clean burst 0x01..0x20. Fields: cyc,pass,fail,tmo,ovr,udf,err,beats,fe_idx,fe_exp,fe_act
    run_burst(32, -1, 8'h00, -1);
    q_a.push_back('{cyc + 1, 1, 0, 0, 0, 0, 0, 32, 0, 0, 0});
    idle(3);
    pulse_clr();
    chk("clr_pass",     32'(pass_a),     32'd0);
    chk("clr_beat_cnt", 32'(beat_cnt_a), 32'd0);
    chk("clr_done",     32'(done_a),     32'd0);

    // Beat 4 corrupted to 0x55.
    run_burst(32, 4, 8'h55, -1);
    q_a.push_back('{cyc + 1, 0, 1, 0, 0, 0, 1, 32, FE_IDX, FE_EXP, FE_ACT});
    idle(3);
    pulse_clr();
    chk("clr_err_cnt", 32'(err_cnt_a), 32'd0);
    chk("clr_fail",    32'(fail_a),    32'd0);

    // clr and rd_ready together in IDLE: beat is dropped.
    drive(1'b1, 8'h01, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("clr_wins_beat_cnt", 32'(beat_cnt_a), 32'd0);
    chk("clr_wins_err_cnt",  32'(err_cnt_a),  32'd0);

    // 20 good beats, then silence until timeout.
    run_burst(20, -1, 8'h00, -1);
    q_a.push_back('{cyc + 64, 0, 1, 1, 0, 0, 0, 20, 0, 0, 0});
    idle(70);
    chk("timeout_hold_beat_cnt", 32'(beat_cnt_a), 32'd20);
    pulse_clr();

    // Full burst then a 33rd beat.
    run_burst(32, -1, 8'h00, -1);
    q_a.push_back('{cyc + 1, 1, 0, 0, 0, 0, 0, 32, 0, 0, 0});
    idle(2);
    chk("pre_overrun_pass", 32'(pass_a), 32'd1);
    drive(1'b1, 8'h21, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("overrun_flag",     32'(overrun_a),  32'd1);
    chk("overrun_pass",     32'(pass_a),     32'd0);
    chk("overrun_fail",     32'(fail_a),     32'd1);
    chk("overrun_beat_cnt", 32'(beat_cnt_a), 32'd32);
    chk("overrun_no_done",  32'(done_a),     32'd0);
    pulse_clr();

    // Empty high the cycle before beat 10: underflow, burst still completes.
    run_burst(32, -1, 8'h00, 10);
    q_a.push_back('{cyc + 1, 0, 1, 0, 0, 1, 0, 32, 0, 0, 0});
    idle(3);
    pulse_clr();

    // Reset during beat 10, then a clean burst.
    run_burst(10, -1, 8'h00, -1);
    @(posedge sysclk);
    #1;
    rst       = 1'b1;
    rd_ready  = 1'b1;
    fifo_dout = 8'h0B;
    @(posedge sysclk);
    #1;
    rst      = 1'b0;
    rd_ready = 1'b0;
    chk("midrst_beat_cnt", 32'(beat_cnt_a), 32'd0);
    chk("midrst_fail",     32'(fail_a),     32'd0);
    run_burst(32, -1, 8'h00, -1);
    q_a.push_back('{cyc + 1, 1, 0, 0, 0, 0, 0, 32, 0, 0, 0});
    idle(3);
    pulse_clr();

    // Second instance: pattern 0xF0..0x0F wraps through 0xFF -> 0x00.
    for (int i = 0; i < 32; i++) begin
      @(posedge sysclk);
      #1;
      rd_ready_b = 1'b1;
      dout_b     = 8'(240 + i);
    end
    q_b.push_back('{cyc + 1, 1, 0, 0, 0, 0, 0, 32, 0, 0, 0});
    @(posedge sysclk);
    #1;
    rd_ready_b = 1'b0;

    idle(5);
    chk("queue_a_drained", 32'(q_a.size()), 32'd0);
    chk("queue_b_drained", 32'(q_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
